fetch_unit: RTL

Instruction-fetch stage of the pipeline and the producer side of the IF/ID interface. It owns the fetch PC, issues one instruction-memory request at a time, and registers the returned word plus its PC into the IF/ID register that the ID-stage decoder consumes. It also handles stall from the hazard unit, redirect/flush from EX, and discards responses that became stale because of a redirect.

---
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps a single instruction-memory
// request in flight, and fills the IF/ID register consumed by the decoder.
// It handles stall, redirect/flush, and drops responses made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_instruction
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic        r_discard;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_insn;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_insn;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_req_pc_nxt;
  logic        w_discard_nxt;
  logic [31:0] w_hold_pc_nxt;
  logic [31:0] w_hold_insn_nxt;
  logic        w_if_id_valid_nxt;
  logic [31:0] w_if_id_pc_nxt;
  logic [31:0] w_if_id_insn_nxt;

  logic        w_req_fire;
  logic        w_load;
  logic [31:0] w_load_pc;
  logic [31:0] w_load_insn;
  logic [31:0] w_redirect_target;

  assign w_req_fire        = (r_state == ST_REQ) && i_imem_req_ready;
  assign w_redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

  assign o_imem_req_valid    = (r_state == ST_REQ);
  assign o_imem_req_addr     = r_fetch_pc;
  assign o_if_id_valid       = r_if_id_valid;
  assign o_if_id_pc          = r_if_id_pc;
  assign o_if_id_instruction = r_if_id_insn;

  // Fetch control: next state, PCs, discard flag, hold buffer and IF/ID word select
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_req_pc_nxt    = r_req_pc;
    w_discard_nxt   = r_discard;
    w_hold_pc_nxt   = r_hold_pc;
    w_hold_insn_nxt = r_hold_insn;
    w_load          = 1'b0;
    w_load_pc       = r_req_pc;
    w_load_insn     = i_imem_rsp_data;

    if (i_redirect) begin
      // Redirect wins over everything; the target is never post-incremented.
      w_fetch_pc_nxt = w_redirect_target;
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            // Request to the old path already accepted: its answer must be dropped.
            w_req_pc_nxt  = r_fetch_pc;
            w_discard_nxt = 1'b1;
            w_state_nxt   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_rsp_valid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_REQ;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_BOOT: w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (w_req_fire) begin
            w_req_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_rsp_valid) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = ST_REQ;
            end else if (!i_stall) begin
              w_load      = 1'b1;
              w_state_nxt = ST_REQ;
            end else begin
              w_hold_pc_nxt   = r_req_pc;
              w_hold_insn_nxt = i_imem_rsp_data;
              w_state_nxt     = ST_HOLD;
            end
          end
        end
        default: begin
          if (!i_stall) begin
            w_load      = 1'b1;
            w_load_pc   = r_hold_pc;
            w_load_insn = r_hold_insn;
            w_state_nxt = ST_REQ;
          end
        end
      endcase
    end
  end

  // IF/ID next value: flush on redirect, load a word, bubble, or hold under stall
  always_comb begin
    w_if_id_valid_nxt = r_if_id_valid;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_insn_nxt  = r_if_id_insn;
    if (i_redirect) begin
      w_if_id_valid_nxt = 1'b0;
      w_if_id_insn_nxt  = NOP_INSN;
    end else if (w_load) begin
      w_if_id_valid_nxt = 1'b1;
      w_if_id_pc_nxt    = w_load_pc;
      w_if_id_insn_nxt  = w_load_insn;
    end else if (!i_stall) begin
      w_if_id_valid_nxt = 1'b0;
      w_if_id_insn_nxt  = NOP_INSN;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC_ALIGNED;
      r_req_pc      <= 32'h0;
      r_discard     <= 1'b0;
      r_hold_pc     <= 32'h0;
      r_hold_insn   <= NOP_INSN;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= 32'h0;
      r_if_id_insn  <= NOP_INSN;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_req_pc      <= w_req_pc_nxt;
      r_discard     <= w_discard_nxt;
      r_hold_pc     <= w_hold_pc_nxt;
      r_hold_insn   <= w_hold_insn_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_insn  <= w_if_id_insn_nxt;
    end
  end

endmodule
